// File: rtl/carry_save_accumulate.sv
// carry_save_accumulate: streaming multi-operand accumulator.
// Operands are folded into a redundant sum/carry pair with one 3:2
// compression per accepted beat. At end of frame, a chunked
// carry-propagate resolve (L bits per cycle) produces the binary sum.
//
// Handshake: an input beat transfers on a rising edge where
// in_valid & in_ready are both high. A result transfers on a rising edge
// where out_valid & out_ready are both high. A valid output holds c/co/beats
// stable until it transfers. in_ready and out_valid depend only on
// registered state.
module carry_save_accumulate #(
  parameter int N = 32,
  parameter int M = 8,
  parameter int L = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic         ci,
  input  logic         last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c,
  output logic         co,
  output logic [M:0]   beats
);

  localparam int W  = N + M;
  localparam int R  = W / L;
  localparam int IW = (R > 1) ? $clog2(R) : 1;

  // Beat counts above 2^M can overflow the guard bits.
  localparam logic [M:0] GUARD_LIM = {1'b1, {M{1'b0}}};

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic          first;
  logic [W-1:0]  s_vec;
  logic [W-1:0]  k_vec;
  logic [W-1:0]  res;
  logic [M:0]    cnt;
  logic [IW-1:0] idx;
  logic          rcarry;
  logic          ov_q;
  logic [N-1:0]  c_q;
  logic          co_q;
  logic [M:0]    beats_q;

  logic          accept;
  logic          handshake;
  logic [W-1:0]  a_ext;
  logic [W-1:0]  maj;
  logic [L:0]    chunk_sum;

  // Handshake decode, operand extension and the current resolve chunk.
  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = ov_q;
    accept    = in_ready & in_valid;
    handshake = ov_q & out_ready;
    a_ext     = W'(a);
    maj       = (s_vec & k_vec) | (s_vec & a_ext) | (k_vec & a_ext);
    chunk_sum = {1'b0, s_vec[int'(idx)*L +: L]}
              + {1'b0, k_vec[int'(idx)*L +: L]}
              + (L+1)'(rcarry);
    c         = c_q;
    co        = co_q;
    beats     = beats_q;
  end

  // Next-state decode for the frame/resolve/output sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (accept && last)         state_nxt = RESOLVE;
      RESOLVE: if (idx == IW'(R - 1))      state_nxt = OUTPUT;
      OUTPUT:  if (handshake)              state_nxt = ACCUM;
      default:                             state_nxt = ACCUM;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  // Carry-save accumulation, chunked resolve and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      first   <= 1'b1;
      s_vec   <= '0;
      k_vec   <= '0;
      res     <= '0;
      cnt     <= '0;
      idx     <= '0;
      rcarry  <= 1'b0;
      ov_q    <= 1'b0;
      c_q     <= '0;
      co_q    <= 1'b0;
      beats_q <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (first) begin
              s_vec <= a_ext;
              k_vec <= W'(ci);
              cnt   <= (M+1)'(1);
              first <= 1'b0;
            end else begin
              s_vec <= s_vec ^ k_vec ^ a_ext;
              k_vec <= maj << 1;
              cnt   <= (cnt == '1) ? cnt : cnt + 1'b1;
            end
            if (last) begin
              idx    <= '0;
              rcarry <= 1'b0;
            end
          end
        end
        RESOLVE: begin
          res[int'(idx)*L +: L] <= chunk_sum[L-1:0];
          rcarry                <= chunk_sum[L];
          idx                   <= idx + 1'b1;
        end
        OUTPUT: begin
          // First cycle in OUTPUT latches the result; it then holds until taken.
          if (!ov_q) begin
            ov_q    <= 1'b1;
            c_q     <= res[N-1:0];
            co_q    <= (|res[W-1:N]) | (cnt > GUARD_LIM);
            beats_q <= cnt;
          end else if (out_ready) begin
            ov_q  <= 1'b0;
            first <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_carry_save_accumulate.sv
// Bench for carry_save_accumulate with N=8, M=4, L=4 (W=12, R=3).
module tb_carry_save_accumulate;

  localparam int N = 8;
  localparam int M = 4;
  localparam int L = 4;
  localparam int W = N + M;
  localparam int R = W / L;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic         ci;
  logic         last;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] c;
  logic         co;
  logic [M:0]   beats;

  int n_cmp = 0;
  int n_bad = 0;

  logic [N-1:0] frame_q[$];
  logic [31:0]  exp_q[$];

  carry_save_accumulate #(.N(N), .M(M), .L(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .ci        (ci),
    .last      (last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .co        (co),
    .beats     (beats)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_c"}, c, 0);
    check({tag, "_co"}, co, 0);
    check({tag, "_beats"}, beats, 0);
  endtask

  // Offer one beat, with random idle cycles, until it is accepted.
  task automatic send_beat(input logic [N-1:0] val, input logic cin, input logic is_last,
                           input int gap_pct, output bit ok);
    int  guard;
    bit  took;
    guard = 0;
    ok    = 0;
    while (guard < 200) begin
      if ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        a        = N'($urandom);
        ci       = 1'($urandom);
        last     = 1'($urandom);
      end else begin
        in_valid = 1'b1;
        a        = val;
        ci       = cin;
        last     = is_last;
      end
      took = in_valid && in_ready;
      @(posedge clk); #1;
      guard++;
      if (took) begin
        ok = 1;
        break;
      end
    end
    in_valid = 1'b0;
    a        = N'($urandom);
    last     = 1'b0;
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  // Reference: plain integer sum of the frame; co from width or guard overflow.
  task automatic model_frame(input logic cin);
    int total;
    int n;
    int tw;
    n     = frame_q.size();
    total = int'(cin);
    foreach (frame_q[i]) total += int'(frame_q[i]);
    tw = total % (1 << W);
    exp_q.push_back(32'(total % (1 << N)));
    exp_q.push_back(32'((tw >= (1 << N)) || (n > (1 << M))));
    exp_q.push_back(32'((n > (1 << (M+1)) - 1) ? (1 << (M+1)) - 1 : n));
  endtask

  // Drive frame_q, check latency, result, backpressure hold and release.
  task automatic run_frame(input logic cin, input int gap_pct, input int hold);
    int          n;
    int          cyc;
    bit          ok;
    logic [31:0] e_c, e_co, e_beats;
    logic [N-1:0] h_c;
    logic        h_co;
    logic [M:0]  h_beats;
    n = frame_q.size();
    model_frame(cin);
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      send_beat(frame_q[i], (i == 0) ? cin : 1'($urandom), (i == n - 1), gap_pct, ok);
      if (!ok) return;
    end
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      check("busy_in_ready", in_ready, 0);
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", cyc, R + 1);
    e_c     = exp_q.pop_front();
    e_co    = exp_q.pop_front();
    e_beats = exp_q.pop_front();
    check("c", c, e_c);
    check("co", co, e_co);
    check("beats", beats, e_beats);
    h_c = c; h_co = co; h_beats = beats;
    for (int j = 0; j < hold; j++) begin
      in_valid = 1'($urandom);
      a        = N'($urandom);
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_c", c, e_c);
      check("hold_co", co, e_co);
      check("hold_beats", beats, e_beats);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
  endtask

  initial begin
    bit ok;
    rst = 1'b1; in_valid = 1'b0; a = '0; ci = 1'b0; last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    frame_q = '{8'd3, 8'd5, 8'd7};
    run_frame(1'b0, 0, 0);

    frame_q = '{8'hFF};
    run_frame(1'b1, 0, 0);

    frame_q = {};
    repeat (8) frame_q.push_back(8'hFF);
    run_frame(1'b0, 0, 0);

    frame_q = '{8'd1, 8'd2};
    run_frame(1'b0, 0, 10);
    frame_q = '{8'd4};
    run_frame(1'b0, 0, 0);

    frame_q = {};
    repeat (20) frame_q.push_back(8'h01);
    run_frame(1'b0, 0, 0);

    // Abort a frame mid-stream with reset.
    send_beat(8'd11, 1'b1, 1'b0, 0, ok);
    send_beat(8'd13, 1'b0, 1'b0, 0, ok);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("abort");
    frame_q = '{8'd9};
    run_frame(1'b0, 0, 0);

    // Randomized frames, including lengths past the guard limit.
    for (int f = 0; f < 14; f++) begin
      int len;
      len = $urandom_range(1, 36);
      frame_q = {};
      for (int i = 0; i < len; i++) frame_q.push_back(N'($urandom));
      run_frame(1'($urandom), $urandom_range(0, 40), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
